// File: rtl/adc_acq_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : adc_acq_sequencer
//  Description : Acquisition sequencer in front of an SPI ADC controller.
//                Issues acquisition starts (single / periodic / continuous),
//                forwards register-write commands, block-averages conversion
//                results and queues them in an output FIFO with sticky
//                overflow / missed / timeout status.
//  Revision    : 1.0  initial release
// ============================================================================
module adc_acq_sequencer #(
    parameter int DATA_WIDTH     = 32,
    parameter int FIFO_DEPTH     = 8,
    parameter int AVG_MAX_LOG2   = 4,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                                aclk,
    input  logic                                areset,
    input  logic [1:0]                          mode,
    input  logic [31:0]                         period,
    input  logic [$clog2(AVG_MAX_LOG2+1)-1:0]   avg_log2,
    input  logic                                trigger_acq,
    input  logic                                clear_status,
    input  logic [31:0]                         s_axis_tdata,
    input  logic                                s_axis_tvalid,
    output logic                                s_axis_tready,
    output logic [DATA_WIDTH-1:0]               m_axis_tdata,
    output logic                                m_axis_tvalid,
    input  logic                                m_axis_tready,
    output logic                                ctl_start_acq,
    output logic                                ctl_start_reg_wrt,
    output logic [23:0]                         ctl_reg_cmd,
    input  logic                                ctl_acq_done,
    input  logic                                ctl_reg_wrt_done,
    input  logic [DATA_WIDTH-1:0]               ctl_cnv_data,
    input  logic                                ctl_busy,
    output logic                                ready,
    output logic                                overflow,
    output logic                                missed,
    output logic                                timeout
);

    localparam int c_AVG_W = $clog2(AVG_MAX_LOG2 + 1);
    localparam int c_ACC_W = DATA_WIDTH + AVG_MAX_LOG2;
    localparam int c_CNT_W = AVG_MAX_LOG2 + 1;
    localparam int c_PTR_W = $clog2(FIFO_DEPTH);
    localparam int c_TO_W  = $clog2(TIMEOUT_CYCLES + 1);

    localparam logic [c_TO_W-1:0]  c_TO_LAST  = c_TO_W'(TIMEOUT_CYCLES - 1);
    localparam logic [c_AVG_W-1:0] c_AVG_MAX  = c_AVG_W'(AVG_MAX_LOG2);

    localparam logic [1:0] c_IDLE     = 2'd0;
    localparam logic [1:0] c_WAIT_ACQ = 2'd1;
    localparam logic [1:0] c_WAIT_REG = 2'd2;

    // ------------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------------
    logic [1:0]                r_state;
    logic                      r_start_acq;
    logic                      r_start_reg;
    logic [23:0]               r_reg_cmd;
    logic [c_TO_W-1:0]         r_to_cnt;
    logic [1:0]                r_mode_q;
    logic [31:0]               r_per_cnt;
    logic signed [c_ACC_W-1:0] r_acc;
    logic [c_CNT_W-1:0]        r_cnt;
    logic [c_AVG_W-1:0]        r_avg_lat;
    logic                      r_push;
    logic [DATA_WIDTH-1:0]     r_res;
    logic [DATA_WIDTH-1:0]     r_mem [FIFO_DEPTH];
    logic [c_PTR_W:0]          r_wr_ptr;
    logic [c_PTR_W:0]          r_rd_ptr;
    logic                      r_overflow;
    logic                      r_missed;
    logic                      r_timeout;

    // ------------------------------------------------------------------------
    // Combinational decode
    // ------------------------------------------------------------------------
    logic                      w_ready;
    logic                      w_s_hs;
    logic [1:0]                w_mode_eff;
    logic                      w_mode_chg;
    logic [31:0]               w_period_m1;
    logic                      w_tick;
    logic                      w_trig_pend;
    logic                      w_start;
    logic                      w_to_hit;
    logic                      w_acq_take;
    logic [c_AVG_W-1:0]        w_avg_req;
    logic [c_AVG_W-1:0]        w_avg_cur;
    logic [c_CNT_W-1:0]        w_blk_last;
    logic                      w_final;
    logic signed [c_ACC_W-1:0] w_sext;
    logic signed [c_ACC_W-1:0] w_acc_next;
    logic signed [c_ACC_W-1:0] w_shifted;
    logic                      w_empty;
    logic                      w_full;
    logic                      w_pop;
    logic                      w_wr_en;
    logic                      w_set_overflow;
    logic                      w_set_missed;
    logic                      w_unused;

    // Ready is forced low while reset is asserted, not just after the edge.
    assign w_ready = (r_state == c_IDLE) && !ctl_busy && !areset;
    assign w_s_hs  = s_axis_tvalid && w_ready;

    // Mode 3 is reserved and behaves as single mode.
    assign w_mode_eff  = (mode == 2'd3) ? 2'd0 : mode;
    assign w_mode_chg  = (mode != r_mode_q);
    assign w_period_m1 = (period == 32'd0) ? 32'd0 : (period - 32'd1);
    assign w_tick      = (w_mode_eff == 2'd1) && !w_mode_chg && (r_per_cnt == 32'd0);

    always_comb begin
        w_trig_pend = 1'b0;
        case (w_mode_eff)
            2'd0:    w_trig_pend = trigger_acq;
            2'd1:    w_trig_pend = w_tick;
            2'd2:    w_trig_pend = 1'b1;
            default: w_trig_pend = 1'b0;
        endcase
    end

    // Register commands take priority over any acquisition trigger.
    assign w_start      = w_ready && !w_s_hs && w_trig_pend;
    // A periodic tick that cannot start an acquisition right now is lost.
    assign w_set_missed = w_tick && !w_start;

    assign w_to_hit = (r_to_cnt == c_TO_LAST) &&
                      (((r_state == c_WAIT_ACQ) && !ctl_acq_done) ||
                       ((r_state == c_WAIT_REG) && !ctl_reg_wrt_done));

    // Averaging datapath; the exponent is taken live on the first sample of
    // a block and from the latched copy afterwards.
    assign w_acq_take = (r_state == c_WAIT_ACQ) && ctl_acq_done;
    assign w_avg_req  = (avg_log2 > c_AVG_MAX) ? c_AVG_MAX : avg_log2;
    assign w_avg_cur  = (r_cnt == '0) ? w_avg_req : r_avg_lat;
    assign w_blk_last = (c_CNT_W'(1) << w_avg_cur) - c_CNT_W'(1);
    assign w_final    = (r_cnt == w_blk_last);
    assign w_sext     = $signed({{AVG_MAX_LOG2{ctl_cnv_data[DATA_WIDTH-1]}}, ctl_cnv_data});
    assign w_acc_next = r_acc + w_sext;
    assign w_shifted  = w_acc_next >>> w_avg_cur;

    // FIFO status; a pop in the same cycle frees room for a push into a full FIFO.
    assign w_empty        = (r_wr_ptr == r_rd_ptr);
    assign w_full         = (r_wr_ptr[c_PTR_W] != r_rd_ptr[c_PTR_W]) &&
                            (r_wr_ptr[c_PTR_W-1:0] == r_rd_ptr[c_PTR_W-1:0]);
    assign w_pop          = !w_empty && m_axis_tready;
    assign w_wr_en        = r_push && (!w_full || w_pop);
    assign w_set_overflow = r_push && w_full && !w_pop;

    // Upper command bits carry no meaning for the controller.
    assign w_unused = ^s_axis_tdata[31:24];

    // ------------------------------------------------------------------------
    // Main sequencing FSM: start pulses, command holding, wait timeouts
    // ------------------------------------------------------------------------
    always_ff @(posedge aclk) begin
        if (areset) begin
            r_state     <= c_IDLE;
            r_start_acq <= 1'b0;
            r_start_reg <= 1'b0;
            r_reg_cmd   <= 24'd0;
            r_to_cnt    <= '0;
        end else begin
            r_start_acq <= 1'b0;
            r_start_reg <= 1'b0;
            case (r_state)
                c_IDLE: begin
                    r_to_cnt <= '0;
                    if (w_s_hs) begin
                        r_reg_cmd   <= s_axis_tdata[23:0];
                        r_start_reg <= 1'b1;
                        r_state     <= c_WAIT_REG;
                    end else if (w_start) begin
                        r_start_acq <= 1'b1;
                        r_state     <= c_WAIT_ACQ;
                    end
                end
                c_WAIT_ACQ: begin
                    if (ctl_acq_done || w_to_hit) begin
                        r_state <= c_IDLE;
                    end else begin
                        r_to_cnt <= r_to_cnt + c_TO_W'(1);
                    end
                end
                c_WAIT_REG: begin
                    // An abandoned write also releases the command bus.
                    if (ctl_reg_wrt_done || w_to_hit) begin
                        r_reg_cmd <= 24'd0;
                        r_state   <= c_IDLE;
                    end else begin
                        r_to_cnt <= r_to_cnt + c_TO_W'(1);
                    end
                end
                default: r_state <= c_IDLE;
            endcase
        end
    end

    // Periodic tick generator, restarted whenever the mode input changes
    always_ff @(posedge aclk) begin
        if (areset) begin
            r_per_cnt <= 32'd0;
            r_mode_q  <= 2'd0;
        end else begin
            r_mode_q <= mode;
            if (w_mode_chg || (r_per_cnt == 32'd0)) begin
                r_per_cnt <= w_period_m1;
            end else begin
                r_per_cnt <= r_per_cnt - 32'd1;
            end
        end
    end

    // Block accumulator; a mode change or timeout throws away a partial block
    always_ff @(posedge aclk) begin
        if (areset) begin
            r_acc     <= '0;
            r_cnt     <= '0;
            r_avg_lat <= '0;
            r_push    <= 1'b0;
            r_res     <= '0;
        end else begin
            r_push <= 1'b0;
            if (w_mode_chg || w_to_hit) begin
                r_acc <= '0;
                r_cnt <= '0;
            end else if (w_acq_take) begin
                if (r_cnt == '0) begin
                    r_avg_lat <= w_avg_req;
                end
                if (w_final) begin
                    r_res  <= w_shifted[DATA_WIDTH-1:0];
                    r_push <= 1'b1;
                    r_acc  <= '0;
                    r_cnt  <= '0;
                end else begin
                    r_acc <= w_acc_next;
                    r_cnt <= r_cnt + c_CNT_W'(1);
                end
            end
        end
    end

    // FIFO storage; contents need no reset because the pointers define validity
    always_ff @(posedge aclk) begin
        if (w_wr_en) begin
            r_mem[r_wr_ptr[c_PTR_W-1:0]] <= r_res;
        end
    end

    // FIFO pointers
    always_ff @(posedge aclk) begin
        if (areset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_wr_en) begin
                r_wr_ptr <= r_wr_ptr + (c_PTR_W+1)'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + (c_PTR_W+1)'(1);
            end
        end
    end

    // Sticky status flags; a set in the same cycle as a clear is kept
    always_ff @(posedge aclk) begin
        if (areset) begin
            r_overflow <= 1'b0;
            r_missed   <= 1'b0;
            r_timeout  <= 1'b0;
        end else begin
            r_overflow <= (r_overflow && !clear_status) || w_set_overflow;
            r_missed   <= (r_missed   && !clear_status) || w_set_missed;
            r_timeout  <= (r_timeout  && !clear_status) || w_to_hit;
        end
    end

    // ------------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------------
    assign ready             = w_ready;
    assign s_axis_tready     = w_ready;
    assign ctl_start_acq     = r_start_acq;
    assign ctl_start_reg_wrt = r_start_reg;
    assign ctl_reg_cmd       = r_reg_cmd;
    assign m_axis_tvalid     = !w_empty;
    assign m_axis_tdata      = w_empty ? '0 : r_mem[r_rd_ptr[c_PTR_W-1:0]];
    assign overflow          = r_overflow;
    assign missed            = r_missed;
    assign timeout           = r_timeout;

endmodule
`default_nettype wire

// File: tb/tb_adc_acq_sequencer.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module      : tb_adc_acq_sequencer
//  Description : Directed scoreboard bench for adc_acq_sequencer with a
//                behavioural SPI controller model.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_adc_acq_sequencer;

    logic        aclk = 1'b0;
    logic        areset;
    logic [1:0]  mode;
    logic [31:0] period;
    logic [2:0]  avg_log2;
    logic        trigger_acq;
    logic        clear_status;
    logic [31:0] s_axis_tdata;
    logic        s_axis_tvalid;
    logic        s_axis_tready;
    logic [31:0] m_axis_tdata;
    logic        m_axis_tvalid;
    logic        m_axis_tready;
    logic        ctl_start_acq;
    logic        ctl_start_reg_wrt;
    logic [23:0] ctl_reg_cmd;
    logic        ctl_acq_done;
    logic        ctl_reg_wrt_done;
    logic [31:0] ctl_cnv_data;
    logic        ctl_busy;
    logic        ready;
    logic        overflow;
    logic        missed;
    logic        timeout;

    always #5 aclk = ~aclk;

    adc_acq_sequencer #(
        .DATA_WIDTH     (32),
        .FIFO_DEPTH     (8),
        .AVG_MAX_LOG2   (4),
        .TIMEOUT_CYCLES (1024)
    ) dut (
        .aclk              (aclk),
        .areset            (areset),
        .mode              (mode),
        .period            (period),
        .avg_log2          (avg_log2),
        .trigger_acq       (trigger_acq),
        .clear_status      (clear_status),
        .s_axis_tdata      (s_axis_tdata),
        .s_axis_tvalid     (s_axis_tvalid),
        .s_axis_tready     (s_axis_tready),
        .m_axis_tdata      (m_axis_tdata),
        .m_axis_tvalid     (m_axis_tvalid),
        .m_axis_tready     (m_axis_tready),
        .ctl_start_acq     (ctl_start_acq),
        .ctl_start_reg_wrt (ctl_start_reg_wrt),
        .ctl_reg_cmd       (ctl_reg_cmd),
        .ctl_acq_done      (ctl_acq_done),
        .ctl_reg_wrt_done  (ctl_reg_wrt_done),
        .ctl_cnv_data      (ctl_cnv_data),
        .ctl_busy          (ctl_busy),
        .ready             (ready),
        .overflow          (overflow),
        .missed            (missed),
        .timeout           (timeout)
    );

    int          n_pass  = 0;
    int          n_total = 0;
    int          cyc     = 0;
    logic [31:0] exp_q[$];
    logic [31:0] samp_q[$];
    int          start_times[$];
    int          n_starts   = 0;
    int          n_done     = 0;
    int          n_regdone  = 0;
    int          acq_lat    = 3;
    int          reg_lat    = 5;
    bit          no_respond = 1'b0;

    always @(posedge aclk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    // Controller model: acts at the falling edge on the DUT's registered outputs.
    initial begin : ctl_model
        int acq_left = 0;
        int reg_left = 0;
        ctl_busy = 1'b0; ctl_acq_done = 1'b0; ctl_reg_wrt_done = 1'b0; ctl_cnv_data = '0;
        forever begin
            @(negedge aclk);
            ctl_acq_done     = 1'b0;
            ctl_reg_wrt_done = 1'b0;
            if (areset) begin
                acq_left = 0; reg_left = 0; ctl_busy = 1'b0;
            end else if (acq_left > 0) begin
                acq_left--;
                if (acq_left == 0) begin
                    ctl_acq_done = 1'b1;
                    ctl_busy     = 1'b0;
                    ctl_cnv_data = (samp_q.size() > 0) ? samp_q.pop_front() : 32'd0;
                    n_done++;
                end
            end else if (reg_left > 0) begin
                reg_left--;
                if (reg_left == 0) begin
                    ctl_reg_wrt_done = 1'b1;
                    ctl_busy         = 1'b0;
                    n_regdone++;
                end
            end else if (ctl_start_acq && !no_respond) begin
                ctl_busy = 1'b1; acq_left = acq_lat;
            end else if (ctl_start_reg_wrt && !no_respond) begin
                ctl_busy = 1'b1; reg_left = reg_lat;
            end
        end
    end

    // Output monitor and start recorder, sampled after the stimulus has settled.
    always begin
        @(negedge aclk);
        #2;
        if (ctl_start_acq) begin
            n_starts++;
            start_times.push_back(cyc);
        end
        if (!areset && m_axis_tvalid && m_axis_tready) begin
            if (exp_q.size() == 0) begin
                n_total++;
                $display("FAIL unexpected_output: got 0x%0h, none expected", m_axis_tdata);
            end else begin
                check("m_axis_tdata", {32'd0, m_axis_tdata}, {32'd0, exp_q.pop_front()});
            end
        end
    end

    task automatic step(input int n = 1);
        repeat (n) begin
            @(negedge aclk);
            #1;
        end
    endtask

    task automatic wait_ready(input string name, input int budget);
        int k = 0;
        while (!ready && k < budget) begin step(); k++; end
        if (!ready) begin
            n_total++;
            $display("FAIL %s: ready still 0 after %0d cycles, expected 1", name, budget);
        end
    endtask

    task automatic drain(input string name, input int budget);
        int k = 0;
        while (exp_q.size() > 0 && k < budget) begin step(); k++; end
        if (exp_q.size() > 0) begin
            n_total++;
            $display("FAIL %s: %0d outputs missing after %0d cycles, expected 0", name, exp_q.size(), budget);
            exp_q.delete();
        end
    endtask

    task automatic acquire(input logic [31:0] v);
        samp_q.push_back(v);
        wait_ready("acq_ready", 400);
        trigger_acq = 1'b1;
        step();
        trigger_acq = 1'b0;
        step();
        wait_ready("acq_return", 400);
    endtask

    initial begin : stim
        int n0;
        int r0;
        int k;
        areset = 1'b1; mode = 2'd0; period = 32'd0; avg_log2 = 3'd0;
        trigger_acq = 1'b0; clear_status = 1'b0; s_axis_tdata = '0;
        s_axis_tvalid = 1'b0; m_axis_tready = 1'b1;
        step(3);
        // Reset state
        check("reset_ready", ready, 0);
        check("reset_s_tready", s_axis_tready, 0);
        check("reset_outputs", {m_axis_tvalid, ctl_start_acq, ctl_start_reg_wrt, ctl_reg_cmd},  0);
        check("reset_flags", {overflow, missed, timeout}, 0);
        areset = 1'b0;
        step();
        check("ready_after_reset", ready, 1);

        // Single acquisition, no averaging
        n0 = n_starts;
        exp_q.push_back(32'h0000_1234);
        acquire(32'h0000_1234);
        drain("single_drain", 50);
        check("single_start_count", n_starts - n0, 1);

        // Block of four: (10+12-2+4)/4 = 6 ; (-1-1-1-2)>>>2 = -2
        avg_log2 = 3'd2;
        exp_q.push_back(32'd6);
        acquire(32'd10); acquire(32'd12); acquire(32'hFFFF_FFFE);
        step(3);
        check("no_early_output", m_axis_tvalid, 0);
        acquire(32'd4);
        exp_q.push_back(32'hFFFF_FFFE);
        acquire(32'hFFFF_FFFF); acquire(32'hFFFF_FFFF); acquire(32'hFFFF_FFFF); acquire(32'hFFFF_FFFE);
        drain("avg4_drain", 50);

        // Exponent 7 clamps to 4: mean of 0,2,..,30 over 16 samples = 15
        avg_log2 = 3'd7;
        exp_q.push_back(32'd15);
        for (int i = 0; i < 16; i++) acquire(32'(2 * i));
        drain("clamp_drain", 50);

        // Continuous mode into a stalled FIFO: 8 kept, 9th dropped
        avg_log2 = 3'd0;
        m_axis_tready = 1'b0;
        for (int i = 1; i <= 9; i++) samp_q.push_back(32'h100 + 32'(i));
        n0 = n_starts;
        mode = 2'd2;
        k = 0;
        while ((n_starts - n0) < 9 && k < 500) begin step(); k++; end
        check("cont_start_count", n_starts - n0, 9);
        mode = 2'd0;
        wait_ready("cont_return", 50);
        step(4);
        check("overflow_set", overflow, 1);
        check("fifo_valid_full", m_axis_tvalid, 1);
        check("fifo_head_held", m_axis_tdata, 32'h101);
        step(5);
        check("fifo_head_stable", m_axis_tdata, 32'h101);
        clear_status = 1'b1; step(); clear_status = 1'b0;
        check("overflow_cleared", overflow, 0);
        for (int i = 1; i <= 8; i++) exp_q.push_back(32'h100 + 32'(i));
        m_axis_tready = 1'b1;
        drain("cont_drain", 50);

        // Periodic mode, 150-cycle conversions against a 100-cycle period
        avg_log2 = 3'd4;
        acq_lat = 150;
        period = 32'd100;
        check("missed_clear_before", missed, 0);
        r0 = start_times.size();
        mode = 2'd1;
        k = 0;
        while (start_times.size() < r0 + 3 && k < 900) begin step(); k++; end
        if (start_times.size() >= r0 + 3) begin
            check("period_gap_1", start_times[r0+1] - start_times[r0], 200);
            check("period_gap_2", start_times[r0+2] - start_times[r0+1], 200);
        end else begin
            n_total++;
            $display("FAIL period_starts: got %0d starts expected 3", start_times.size() - r0);
        end
        check("missed_set", missed, 1);
        wait_ready("period_return", 200);
        mode = 2'd0;
        acq_lat = 3;
        step(2);
        clear_status = 1'b1; step(); clear_status = 1'b0;

        // Register write wins against a simultaneous trigger
        avg_log2 = 3'd0;
        wait_ready("reg_ready", 50);
        r0 = n_regdone;
        n0 = n_starts;
        samp_q.push_back(32'h0000_0777);
        exp_q.push_back(32'h0000_0777);
        s_axis_tdata = 32'h00AB_CDEF; s_axis_tvalid = 1'b1; trigger_acq = 1'b1;
        step();
        s_axis_tvalid = 1'b0;
        check("reg_start_first", {ctl_start_reg_wrt, ctl_start_acq}, 2'b10);
        check("reg_cmd_latched", ctl_reg_cmd, 24'hABCDEF);
        k = 0;
        while (!ctl_start_acq && k < 50) begin step(); k++; end
        trigger_acq = 1'b0;
        check("acq_after_reg_done", {ctl_start_acq, 8'(n_regdone - r0)}, {1'b1, 8'd1});
        check("reg_cmd_cleared", ctl_reg_cmd, 0);
        wait_ready("reg_acq_return", 50);
        drain("reg_acq_drain", 50);
        check("reg_acq_start_count", n_starts - n0, 1);

        // Leave one word parked in the FIFO so reset has something to clear
        m_axis_tready = 1'b0;
        acquire(32'h55);
        step(3);
        check("parked_word", m_axis_tvalid, 1);

        // Timeout when the controller never answers
        no_respond = 1'b1;
        wait_ready("to_ready", 50);
        trigger_acq = 1'b1; step(); trigger_acq = 1'b0;
        step(1000);
        check("timeout_not_yet", {timeout, ready}, 2'b00);
        step(100);
        check("timeout_set", {timeout, ready}, 2'b11);

        // Reset in the middle of an acquisition wait
        trigger_acq = 1'b1; step(); trigger_acq = 1'b0;
        step(5);
        check("in_wait_acq", ready, 0);
        areset = 1'b1;
        step();
        check("midreset_outputs", {ready, m_axis_tvalid, ctl_start_acq, ctl_start_reg_wrt, ctl_reg_cmd}, 0);
        check("midreset_flags", {overflow, missed, timeout}, 0);
        check("midreset_tdata", m_axis_tdata, 0);
        areset = 1'b0;
        no_respond = 1'b0;
        m_axis_tready = 1'b1;
        step(5);
        check("fifo_empty_after_reset", m_axis_tvalid, 0);
        check("ready_after_midreset", ready, 1);
        check("scoreboard_empty", exp_q.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/adc_acq_sequencer.md
ADC_ACQ_SEQUENCER -- requirements
Module: adc_acq_sequencer

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, conversion word width.
REQ-002 SHALL have parameter FIFO_DEPTH, default 8, output FIFO entries (power of two, >=2).
REQ-003 SHALL have parameter AVG_MAX_LOG2, default 4, maximum averaging exponent.
REQ-004 SHALL have parameter TIMEOUT_CYCLES, default 1024, wait limit for controller done pulses.
REQ-005 Ports, SHALL be exactly as follows; one clock; reset is synchronous and active-high:
  aclk  in  1  system clock
  areset  in  1  synchronous active-high reset
  mode  in  2  0=single (trigger_acq), 1=periodic, 2=continuous, 3=reserved (treated as 0)
  period  in  32  periodic interval in aclk cycles
  avg_log2  in  clog2(AVG_MAX_LOG2+1)  averaging exponent
  trigger_acq  in  1  single-mode acquisition request
  clear_status  in  1  clears sticky flags
  s_axis_tdata/tvalid/tready  in/in/out  32/1/1  register command (bits [23:0] used)
  m_axis_tdata/tvalid/tready  out/out/in  DATA_WIDTH/1/1  averaged samples
  ctl_start_acq  out  1  one-cycle start to SPI controller
  ctl_start_reg_wrt  out  1  one-cycle register-write start
  ctl_reg_cmd  out  24  register command, held stable during write
  ctl_acq_done/ctl_reg_wrt_done  in  1  one-cycle completion pulses
  ctl_cnv_data  in  DATA_WIDTH  conversion word, valid with ctl_acq_done
  ctl_busy  in  1  controller busy
  ready  out  1  IDLE and not ctl_busy
  overflow/missed/timeout  out  1  sticky status flags

Function
REQ-006 SHALL implement states IDLE, WAIT_ACQ, WAIT_REG.
REQ-007 s_axis_tready SHALL equal ready; in IDLE an s_axis handshake SHALL latch ctl_reg_cmd, pulse ctl_start_reg_wrt the next cycle, enter WAIT_REG.
REQ-008 In IDLE with no s_axis handshake and an acquisition trigger pending and ctl_busy low, SHALL pulse ctl_start_acq the next cycle and enter WAIT_ACQ; register commands win simultaneous events.
REQ-009 Trigger sources: mode 0 trigger_acq level sampled in IDLE; mode 1 internal tick; mode 2 always pending.
REQ-010 Mode 1: down-counter loads period-1 (period 0 treated as 1), ticks at 0 and reloads; tick while not IDLE-ready SHALL set missed and be discarded.
REQ-011 WAIT_ACQ: ctl_acq_done SHALL add sign-extended ctl_cnv_data to accumulator of DATA_WIDTH+AVG_MAX_LOG2 bits, increment sample count, return to IDLE.
REQ-012 avg_log2 SHALL be latched at first sample of a block; values above AVG_MAX_LOG2 clamp to AVG_MAX_LOG2; block size 2^avg_log2.
REQ-013 On final sample, result = accumulator arithmetic-shifted right by latched avg_log2, truncated to DATA_WIDTH, pushed to FIFO next cycle; accumulator and count clear.
REQ-014 Push when FIFO full SHALL drop the result and set overflow; FIFO contents unchanged.
REQ-015 m_axis_tvalid SHALL be high whenever FIFO non-empty; pop on tvalid&&tready; simultaneous push and pop when full SHALL succeed (no overflow).
REQ-016 m_axis_tdata SHALL hold stable while tvalid high and tready low.
REQ-017 WAIT_REG: ctl_reg_wrt_done SHALL clear ctl_reg_cmd to 0 and return to IDLE.
REQ-018 Either wait state exceeding TIMEOUT_CYCLES without done SHALL set timeout, return to IDLE, discard the partial average block.
REQ-019 Changing mode SHALL reload the period counter and discard any partial block.
REQ-020 clear_status SHALL clear overflow, missed, timeout; a same-cycle set SHALL win.

Reset
REQ-021 areset SHALL force IDLE, all outputs 0 (ready 0 during reset), FIFO empty, accumulator, count, period counter and flags cleared, regardless of state, on the next aclk edge.

Verification
REQ-022 mode 0, avg_log2=0, trigger_acq pulse, done returns 0x0000_1234 -> one ctl_start_acq, m_axis_tdata=0x0000_1234.
REQ-023 mode 0, avg_log2=2, samples 10,12,-2,4 -> single output 6; samples -1,-1,-1,-2 -> output -2 (0xFFFF_FFFE).
REQ-024 mode 2, m_axis_tready=0, 9 samples, avg_log2=0 -> 8 held, overflow=1, first output unchanged.
REQ-025 mode 1, period=100, controller 150-cycle acquisitions -> missed=1, starts every 200 cycles.
REQ-026 s_axis write 0x00AB_CDEF with trigger_acq same cycle -> ctl_start_reg_wrt first, ctl_reg_cmd=0xABCDEF; acquisition follows done.
REQ-027 No done for 1025 cycles -> timeout=1, IDLE; areset mid-WAIT_ACQ -> all outputs 0 next cycle.
